// File: rtl/parity_checker.sv
// parity_checker: registered per-word parity flags plus a running parity over accepted words
module parity_checker #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    input  logic             acc_clr,
    output logic             even,
    output logic             odd,
    output logic             out_valid,
    output logic             acc_even,
    output logic             acc_odd
);
    logic p;
    logic even_q, even_d, odd_q, odd_d, valid_q, valid_d, acc_q, acc_d;
    always_comb begin
        p       = ^data_in;
        even_d  = in_valid ? ~p : even_q;
        odd_d   = in_valid ? p : odd_q;
        valid_d = valid_q | in_valid;
        // gating p with in_valid keeps an undriven data_in out of the accumulator
        acc_d   = (acc_clr ? 1'b0 : acc_q) ^ (in_valid & p);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            even_q  <= 1'b0;
            odd_q   <= 1'b0;
            valid_q <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            even_q  <= even_d;
            odd_q   <= odd_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
        end
    end
    assign even      = even_q;
    assign odd       = odd_q;
    assign out_valid = valid_q;
    assign acc_even  = ~acc_q;
    assign acc_odd   = acc_q;
endmodule

// File: tb/tb_parity_checker.sv
// tb_parity_checker: directed and random stimulus checked against a ones-counting reference model
module tb_parity_checker;
    localparam int W = 6;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, acc_clr = 1'b0;
    logic [W-1:0] data_in = '0;
    logic even, odd, out_valid, acc_even, acc_odd;
    int checks = 0, errors = 0;
    bit chk_en = 1'b0;
    bit m_even = 0, m_odd = 0, m_valid = 0;
    int m_ones = 0;

    parity_checker #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .acc_clr(acc_clr),
        .even(even), .odd(odd), .out_valid(out_valid), .acc_even(acc_even), .acc_odd(acc_odd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", n, $time, act, exp);
        end
    endtask

    // Reference: word parity from a population count, stream parity from total ones since clear
    always @(posedge clk) begin
        if (rst) begin
            m_even = 0; m_odd = 0; m_valid = 0; m_ones = 0;
        end else begin
            if (acc_clr) m_ones = 0;
            if (in_valid) begin
                m_ones  = m_ones + $countones(data_in);
                m_odd   = ($countones(data_in) % 2) == 1;
                m_even  = !m_odd;
                m_valid = 1;
            end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("even", even, m_even);
        chk("odd", odd, m_odd);
        chk("out_valid", out_valid, m_valid);
        chk("acc_even", acc_even, (m_ones % 2) == 0);
        chk("acc_odd", acc_odd, (m_ones % 2) == 1);
    end

    task automatic drive(input logic r, input logic v, input logic c, input logic [W-1:0] d);
        rst = r; in_valid = v; acc_clr = c; data_in = d;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] words [11] = '{6'b111000, 6'b111010, 6'b000000, 6'b000111, 6'b111111,
                                  6'b100011, 6'b010101, 6'b110011, 6'b100100, 6'b110001, 6'b010011};
    logic exp_odd [11] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        drive(1, 0, 0, '0);
        drive(1, 0, 0, '0);
        chk_en = 1'b1;
        chk("rst_even", even, 1'b0);
        chk("rst_odd", odd, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_acc_even", acc_even, 1'b1);
        chk("rst_acc_odd", acc_odd, 1'b0);
        for (int i = 0; i < 11; i++) begin
            drive(0, 1, 0, words[i]);
            chk($sformatf("word%0d_odd", i), odd, exp_odd[i]);
            chk($sformatf("word%0d_even", i), even, !exp_odd[i]);
            chk($sformatf("word%0d_valid", i), out_valid, 1'b1);
        end
        drive(0, 1, 0, 6'b000111);
        drive(0, 0, 0, 6'b111111);
        chk("hold_odd", odd, 1'b1);
        chk("hold_even", even, 1'b0);
        chk("hold_valid", out_valid, 1'b1);
        drive(0, 0, 1, 6'b111111);
        chk("clr_acc_even", acc_even, 1'b1);
        drive(0, 1, 0, 6'b111000);
        drive(0, 1, 0, 6'b000111);
        drive(0, 1, 0, 6'b100011);
        chk("run3_acc_odd", acc_odd, 1'b1);
        drive(0, 1, 0, 6'b110001);
        chk("run4_acc_even", acc_even, 1'b1);
        drive(0, 1, 1, 6'b010011);
        chk("clrword_acc_odd", acc_odd, 1'b1);
        chk("clrword_acc_even", acc_even, 1'b0);
        drive(0, 1, 0, 6'b111000);
        drive(1, 1, 0, 6'b111111);
        chk("mid_rst_even", even, 1'b0);
        chk("mid_rst_odd", odd, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_acc_even", acc_even, 1'b1);
        chk("mid_rst_acc_odd", acc_odd, 1'b0);
        for (int i = 0; i < 1000; i++)
            drive(($urandom % 64) == 0, $urandom % 2, ($urandom % 8) == 0, W'($urandom));
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
